// File: rtl/sig_gen_sequencer.sv
// Playback scheduler for one signal-generator channel: start delay, N repetitions
// with gaps, blanked end-of-buffer detection. Optional macro EXT_TRIG_EN gates ARMED on ext_trig.
module sig_gen_sequencer #(
    parameter int CNT_WIDTH = 32,
    parameter int REP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] delay_cycles,
    input  logic [CNT_WIDTH-1:0] gap_cycles,
    input  logic [REP_WIDTH-1:0] n_reps,
    input  logic                 ext_trig,
    output logic                 play_en,
    input  logic                 play_finish,
    output logic                 busy,
    output logic                 done,
    output logic [REP_WIDTH-1:0] rep_count,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t               cur, nxt;
    logic [CNT_WIDTH-1:0] cnt, delay_s, gap_s, wait_len;
    logic [REP_WIDTH-1:0] nreps_s, rep_next;
    logic                 trig_go, cnt_hit, finish_ok, last_rep, accept;

`ifdef EXT_TRIG_EN
    // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
    logic [2:0] trig_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_sr <= '0;
        else        trig_sr <= {trig_sr[1:0], ext_trig};
    end

    assign trig_go = trig_sr[1] & ~trig_sr[2];
`else
    logic unused_trig;
    assign unused_trig = ext_trig;
    assign trig_go     = 1'b1;
`endif

    assign accept   = (cur == IDLE) && start && !abort;
    assign wait_len = (cur == DELAY) ? delay_s : gap_s;
    // a zero length still spends one cycle in the state so play_en gets a low cycle
    assign cnt_hit  = (wait_len == '0) || (cnt == wait_len - CNT_WIDTH'(1));
    // reader's flag is stale for the first two PLAY cycles
    assign finish_ok = play_finish && (cnt >= CNT_WIDTH'(2));
    assign rep_next  = (rep_count == '1) ? rep_count : rep_count + REP_WIDTH'(1);
    assign last_rep  = (nreps_s != '0) && (rep_count + REP_WIDTH'(1) == nreps_s);

    always_comb begin
        nxt = cur;
        if (abort && cur != IDLE) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE:    if (accept) nxt = ARMED;
                ARMED:   if (trig_go) nxt = DELAY;
                DELAY:   if (cnt_hit) nxt = PLAY;
                PLAY:    if (finish_ok) nxt = last_rep ? IDLE : GAP;
                GAP:     if (cnt_hit) nxt = PLAY;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= IDLE;
            cnt       <= '0;
            delay_s   <= '0;
            gap_s     <= '0;
            nreps_s   <= '0;
            rep_count <= '0;
            play_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur <= nxt;

            if (nxt != cur || cur == IDLE || cur == ARMED)
                cnt <= '0;
            else if (cur != PLAY || cnt < CNT_WIDTH'(2))
                cnt <= cnt + CNT_WIDTH'(1);

            if (accept) begin
                delay_s   <= delay_cycles;
                gap_s     <= gap_cycles;
                nreps_s   <= n_reps;
                rep_count <= '0;
            end else if (cur == PLAY && !abort && finish_ok) begin
                rep_count <= rep_next;
            end

            done    <= (cur == PLAY) && !abort && finish_ok && last_rep;
            busy    <= (nxt != IDLE);
            // lags state by one cycle on both edges, so low time equals the GAP length
            play_en <= (cur == PLAY) && !abort;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_sig_gen_sequencer.sv
// Bench for sig_gen_sequencer: randomized sequences against a timing model of
// delay/gap/repetition rules, plus directed abort, reset and shadowing steps.
module tb_sig_gen_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] delay_cycles = '0;
    logic [31:0] gap_cycles = '0;
    logic [15:0] n_reps = '0;
    logic        ext_trig = 1'b0;
    logic        play_en;
    logic        play_finish = 1'b1;   // stale flag present before the first run
    logic        busy, done;
    logic [15:0] rep_count;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    int reader_lat = 4;
    int r_cnt = 0;
    logic r_prev = 1'b0;

    sig_gen_sequencer #(.CNT_WIDTH(32), .REP_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .delay_cycles(delay_cycles), .gap_cycles(gap_cycles), .n_reps(n_reps),
        .ext_trig(ext_trig), .play_en(play_en), .play_finish(play_finish),
        .busy(busy), .done(done), .rep_count(rep_count), .state(state)
    );

    always #5 clk = ~clk;

    // reader model: restarts on play_en rise, raises finish reader_lat cycles later, holds it
    always @(negedge clk) begin
        if (play_en && !r_prev) begin
            r_cnt = 0;
            play_finish = 1'b0;
        end else if (play_en && !play_finish) begin
            r_cnt++;
            if (r_cnt >= reader_lat) play_finish = 1'b1;
        end
        r_prev = play_en;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Expected: first play_en high d'+2 cycles after start edge, each high L+2 cycles,
    // each low g' cycles (x' = max(x,1)), exactly n highs, one done on the last high cycle.
    task automatic run_seq(input int d, input int g, input int n, input int l, input bit poke);
        int  t, rises, hi_len, lo_len, dones, done_t, last_hi_t, first_t, dp, gp;
        bit  prev, fin;
        dp = (d == 0) ? 1 : d;
        gp = (g == 0) ? 1 : g;
        reader_lat = l;
        delay_cycles = d; gap_cycles = g; n_reps = 16'(n);
        rises = 0; hi_len = 0; lo_len = 0; dones = 0; done_t = -1; last_hi_t = -2;
        first_t = -1; prev = 0; fin = 0;
        pulse_start();
        for (t = 0; t < 3000; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (play_en && !prev) begin
                rises++;
                if (rises == 1) first_t = t;
                else chk("gap_len", lo_len, gp);
                hi_len = 0;
                if (poke && rises == 1) begin
                    start = 1'b1; n_reps = 16'd1;
                    gap_cycles = g + 5; delay_cycles = d + 3;
                end
            end
            if (!play_en && prev) begin
                chk("high_len", hi_len, l + 2);
                lo_len = 0;
            end
            if (play_en) begin hi_len++; last_hi_t = t; end
            else lo_len++;
            if (done) begin dones++; done_t = t; end
            prev = play_en;
            if (t > 0 && !busy && !play_en) begin fin = 1; break; end
        end
        chk("seq_finished", int'(fin), 1);
        chk("rises", rises, n);
        chk("first_rise", first_t, dp + 2);
        chk("done_count", dones, 1);
        chk("done_pos", done_t, last_hi_t);
        chk("rep_count_end", int'(rep_count), n);
        chk("state_end", int'(state), 0);
    endtask

    initial begin
        int t, dones, lo_len;
        bit prev, seen;

        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_play_en", int'(play_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rep_count", int'(rep_count), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // stale finish held high at first start; delay 3, gap 2, 2 reps, finish 8 after rise
        run_seq(3, 2, 2, 8, 1'b0);

        for (int i = 0; i < 6; i++)
            run_seq($urandom_range(0, 6), $urandom_range(0, 4),
                    $urandom_range(1, 4), $urandom_range(1, 6), 1'b0);

        // start and new config while busy are ignored
        run_seq(2, 1, 3, 3, 1'b1);

        // infinite mode, gap 0: one low cycle per gap, abort after 5 reps
        reader_lat = 3; delay_cycles = 1; gap_cycles = 0; n_reps = 0;
        pulse_start();
        dones = 0; lo_len = 0; prev = 0;
        for (t = 0; t < 500; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            if (play_en && !prev && lo_len > 0 && t > 4) chk("inf_gap_len", lo_len, 1);
            if (play_en) lo_len = 0; else lo_len++;
            if (done) dones++;
            prev = play_en;
            if (rep_count == 16'd5) break;
        end
        chk("inf_reached_5", int'(rep_count), 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_play_en", int'(play_en), 0);
        chk("abort_rep_count", int'(rep_count), 5);
        chk("inf_no_done", dones + int'(done), 0);

        // start with abort in IDLE stays IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_state", int'(state), 0);
        chk("start_abort_busy", int'(busy), 0);

        // abort during DELAY
        delay_cycles = 100; gap_cycles = 1; n_reps = 2;
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        chk("delay_state", int'(state), 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("delay_abort_state", int'(state), 0);
        chk("delay_abort_rep", int'(rep_count), 0);

        // asynchronous reset in the middle of PLAY
        reader_lat = 20; delay_cycles = 0; gap_cycles = 1; n_reps = 2;
        pulse_start();
        seen = 0;
        for (t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (play_en) begin seen = 1; break; end
        end
        chk("mid_play_reached", int'(seen), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_play_en", int'(play_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_rep_count", int'(rep_count), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(1, 3, 2, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
